// File: rtl/fetch_queue.sv
// fetch_queue: first-word-fall-through circular queue of {pcplus4, instr} entries between fetch and decode.
module fetch_queue #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WORD_W-1:0]          pcplus4_in,
  input  logic [WORD_W-1:0]          instr_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WORD_W-1:0]          pcplus4_out,
  output logic [WORD_W-1:0]          instr_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2*WORD_W-1:0] mem_q [DEPTH];
  logic [2*WORD_W-1:0] mem_d [DEPTH];
  logic [2*WORD_W-1:0] head;
  logic push, pop;
  assign in_ready    = count_q < FULL;
  assign out_valid   = count_q != '0;
  assign count       = count_q;
  assign head        = mem_q[rd_ptr_q];
  assign pcplus4_out = out_valid ? head[2*WORD_W-1:WORD_W] : '0;
  assign instr_out   = out_valid ? head[WORD_W-1:0] : '0;
  always_comb begin
    push = in_valid && in_ready && !flush;
    pop  = out_valid && out_ready && !flush;
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {pcplus4_in, instr_in};
    wr_ptr_d = flush ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = flush ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = flush ? '0 :
               (push && !pop) ? count_q + CW'(1) :
               (pop && !push) ? count_q - CW'(1) : count_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter WORD_W, default 32, width of the PC+4 and instruction words.
REQ-002 Parameter DEPTH, default 4, number of entries; SHALL be a power of two and at least 2.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 CLK  input  1  clock; all state updates on its rising edge.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 pcplus4_in  input  WORD_W  PC+4 of the fetched instruction.
REQ-007 instr_in  input  WORD_W  fetched instruction.
REQ-008 in_valid  input  1  fetch side offers an entry this cycle.
REQ-009 in_ready  output  1  queue can accept an entry this cycle.
REQ-010 pcplus4_out  output  WORD_W  PC+4 of the head entry.
REQ-011 instr_out  output  WORD_W  instruction of the head entry.
REQ-012 out_valid  output  1  head entry is present.
REQ-013 out_ready  input  1  decode side consumes the head this cycle; this is the stall input (0 = stall).
REQ-014 flush  input  1  discard all entries, e.g. on a taken branch or jump.
REQ-015 count  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH entries of {pcplus4, instr}, with a write pointer, a read pointer and an occupancy counter.
REQ-017 Push SHALL occur when in_valid && in_ready && !flush; the entry is written at the write pointer, which then increments modulo DEPTH.
REQ-018 Pop SHALL occur when out_valid && out_ready && !flush; the read pointer increments modulo DEPTH.
REQ-019 in_ready SHALL equal (count < DEPTH) and SHALL depend only on registered state, with no combinational path from out_ready.
REQ-020 out_valid SHALL equal (count != 0); output is first-word-fall-through, so pcplus4_out and instr_out show the head entry in the same cycle out_valid is high.
REQ-021 pcplus4_out and instr_out SHALL be 0 whenever out_valid is 0.
REQ-022 Latency SHALL be one cycle: an entry pushed in cycle N is visible at the outputs in cycle N+1.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and move both pointers.
REQ-024 When full, a push SHALL NOT occur even if a pop occurs in the same cycle (in_ready=0); count drops to DEPTH-1 after that cycle.
REQ-025 When empty, a push SHALL NOT bypass to the outputs in the same cycle; out_valid rises in the next cycle.
REQ-026 When flush=1, the queue SHALL set both pointers and count to 0 on the next edge; flush overrides any concurrent push or pop, and a flushed cycle consumes nothing.
REQ-027 Pointer wrap from DEPTH-1 to 0 SHALL preserve FIFO order.
REQ-028 count SHALL never exceed DEPTH and never underflow.

Reset
REQ-029 When RST=1 at a rising edge, pointers, count and all storage entries SHALL clear to 0; RST has priority over flush, push and pop.
REQ-030 After reset: out_valid=0, pcplus4_out=0, instr_out=0, count=0, in_ready=1.
REQ-031 Reset asserted mid-operation with entries held SHALL discard them; the first entry pushed after reset is the first one popped.

Verification
REQ-032 Fill with DEPTH=4 and out_ready=0: push instr 0xA0..0xA3 -> count=4 and in_ready=0; a 5th offer is not accepted.
REQ-033 Drain after fill, out_ready=1 -> instr_out shows 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles, then out_valid=0 and instr_out=0.
REQ-034 Steady streaming with in_valid=out_ready=1 for 10 pushes across a pointer wrap -> count stays at 1 and the output order matches the input order.
REQ-035 Flush with count=3 while in_valid=1 and out_ready=1 -> next cycle count=0 and out_valid=0; the offered entry is dropped.
REQ-036 Full with pop in the same cycle as an offered push -> count=3 after the edge and the offered entry is not stored.
REQ-037 RST=1 with count=2 -> next cycle count=0; then push 0x55 -> instr_out=0x55 one cycle later.
